// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and defaults for the button debouncer slice.
//   - state_e        : debouncer FSM encoding (2 bits)
//   - DEFAULT_CNT_WIDTH : default stability-counter width
//   - is_wait()      : true for the two qualification states
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } state_e;

    localparam int DEFAULT_CNT_WIDTH = 8;

    // A candidate transition is being qualified only in the WAIT states.
    function automatic logic is_wait(input state_e st);
        return (st == ST_WAIT_HI) || (st == ST_WAIT_LO);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// -----------------------------------------------------------------------------
// button_debouncer_if
//   Groups the debouncer's data signals. Clock and reset stay plain ports.
//   btn_in    : raw asynchronous button input (driven by master)
//   btn_level : debounced level
//   btn_rise  : one-cycle pulse on 0->1 of btn_level
//   btn_fall  : one-cycle pulse on 1->0 of btn_level
//   busy      : a candidate transition is being qualified
//   modport master : button/bench side; modport slave : debouncer side
// -----------------------------------------------------------------------------
interface button_debouncer_if;
    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic busy;

    modport master (output btn_in, input btn_level, btn_rise, btn_fall, busy);
    modport slave  (input btn_in, output btn_level, btn_rise, btn_fall, busy);
endinterface

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   Plain STAGES-deep flop chain bringing an asynchronous bit into clk domain.
//   clk   : clock
//   rst_n : synchronous active-low reset, loads RESET_VAL into every stage
//   d     : asynchronous input
//   q     : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw input through the synchronizer stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_r <= {STAGES{RESET_VAL}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Turns a bouncy asynchronous button into a clean synchronous level plus
//   single-cycle rise/fall pulses. A new level is accepted only after the
//   synchronized input has held it for STABLE_CYCLES consecutive cycles.
//   clk   : clock, all state on posedge
//   rst_n : synchronous active-low reset
//   bus   : button_debouncer_if.slave (btn_in in; btn_level, btn_rise,
//           btn_fall, busy out, all registered)
// -----------------------------------------------------------------------------
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter int   CNT_WIDTH     = DEFAULT_CNT_WIDTH,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    button_debouncer_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam state_e RESET_STATE = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;
    // With a single required cycle the WAIT states are skipped entirely.
    localparam logic SINGLE_CYCLE = (STABLE_CYCLES == 32'sd1);

    logic                 sync_s;
    state_e               state_r, state_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
    logic                 level_r, level_s;
    logic                 rise_r, rise_s;
    logic                 fall_r, fall_s;
    logic                 busy_r;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_in),
        .q     (sync_s)
    );

    // Next-state, counter and output-pulse decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        level_s = level_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        case (state_r)
            ST_STABLE_LO: begin
                cnt_s = CNT_ZERO;
                if (sync_s) begin
                    if (SINGLE_CYCLE) begin
                        state_s = ST_STABLE_HI;
                        level_s = 1'b1;
                        rise_s  = 1'b1;
                    end else begin
                        state_s = ST_WAIT_HI;
                        cnt_s   = CNT_ONE;
                    end
                end else begin
                    state_s = ST_STABLE_LO;
                end
            end
            ST_WAIT_HI: begin
                if (!sync_s) begin
                    state_s = ST_STABLE_LO;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_STABLE_HI;
                    cnt_s   = CNT_ZERO;
                    level_s = 1'b1;
                    rise_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STABLE_HI: begin
                cnt_s = CNT_ZERO;
                if (!sync_s) begin
                    if (SINGLE_CYCLE) begin
                        state_s = ST_STABLE_LO;
                        level_s = 1'b0;
                        fall_s  = 1'b1;
                    end else begin
                        state_s = ST_WAIT_LO;
                        cnt_s   = CNT_ONE;
                    end
                end else begin
                    state_s = ST_STABLE_HI;
                end
            end
            ST_WAIT_LO: begin
                if (sync_s) begin
                    state_s = ST_STABLE_HI;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_STABLE_LO;
                    cnt_s   = CNT_ZERO;
                    level_s = 1'b0;
                    fall_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = RESET_STATE;
                cnt_s   = CNT_ZERO;
                level_s = RESET_LEVEL;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts any qualification.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= RESET_STATE;
            cnt_r   <= CNT_ZERO;
            level_r <= RESET_LEVEL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            level_r <= level_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
            busy_r  <= is_wait(state_s);
        end
    end

    assign bus.btn_level = level_r;
    assign bus.btn_rise  = rise_r;
    assign bus.btn_fall  = fall_r;
    assign bus.busy      = busy_r;

endmodule
